slice_rd_sched: RTL and testbench
=================================

Name: slice_rd_sched

Overview:
- Read scheduler for the per-slice output sync buffers in the decoder output path, in the clk_out_int domain.
- Walks slices left-to-right, one chunk (one slice line) at a time, and issues one-hot read enables.
- Tracks pixel-group, slice and line position; produces the per-pixel valid mask, end-of-line and end-of-frame for the merged 4-pixel output stream.
- Sits between the per-slice buffers and the output pixel mux; its pipelined slice select drives that mux.

Parameters:
- MAX_NBR_SLICES, 2, number of slice buffers/read ports.
- MAX_SLICE_WIDTH, 2560, maximum slice width in pixels; sizes slice_width and the group counter.

Ports:
- clk_out_int  in  1  output-side clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin (or restart) a frame.
- slices_per_line  in  10  slices per picture line, 1..MAX_NBR_SLICES.
- slice_width  in  $clog2(MAX_SLICE_WIDTH)  slice width in pixels, multiple of 4, >=8.
- frame_height  in  16  picture lines per frame, >=1.
- eoc_valid_pixs  in  3  valid pixels in last group of each chunk, 1..4; 0 treated as 4.
- buf_empty  in  MAX_NBR_SLICES  per-slice buffer empty.
- out_ready  in  1  downstream can accept a group this cycle.
- rd_en  out  MAX_NBR_SLICES  one-hot buffer read enable.
- rd_sel  out  $clog2(MAX_NBR_SLICES)  slice currently being read.
- out_sel  out  $clog2(MAX_NBR_SLICES)  rd_sel delayed 1 cycle; aligned with buffer data, drives the pixel mux.
- out_valid  out  4  per-pixel valid of the output group.
- out_eol  out  1  output group is the last of a picture line.
- out_eof  out  1  output group is the last of the frame.
- busy  out  1  frame in progress.
- cfg_err  out  1  sticky: last start rejected.

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0. rst has priority over start.
- Derived values: last_grp = (slice_width>>2)-1. grp_cnt width $clog2((MAX_SLICE_WIDTH>>2)+1). line_cnt is 16 bits.
- FSM states: IDLE, RUN, DONE.
- IDLE, start with valid config: go to RUN; clear grp_cnt, rd_sel and line_cnt; clear cfg_err.
- Config check: slices_per_line in 1..MAX_NBR_SLICES, slice_width>=8, slice_width[1:0]==0, frame_height!=0.
- IDLE, start with invalid config: stay IDLE; set cfg_err=1, held until the next accepted start.
- RUN, issue condition: issue = ~buf_empty[rd_sel] & out_ready. rd_en = issue ? (1<<rd_sel) : 0. rd_en is combinational from state/registers.
- RUN, issue with grp_cnt<last_grp: grp_cnt+1.
- RUN, issue with grp_cnt==last_grp: grp_cnt=0.
  - rd_sel<slices_per_line-1: rd_sel+1.
  - Otherwise: rd_sel=0 and line_cnt+1.
  - If additionally line_cnt==frame_height-1: go to DONE.
- DONE: rd_en=0; next cycle go to IDLE.
- busy = state!=IDLE.
- Stall: no issue leaves all counters unchanged. Empty on one slice blocks all slices; there is no skip-ahead.
- Output stage: registered, latency exactly 1 cycle after rd_en.
  - out_sel = registered rd_sel.
  - out_valid = 4'b1111, except on the last group of a chunk = mask of eoc_valid_pixs LSBs (1->0001, 2->0011, 3->0111, 4/0->1111).
  - out_eol = 1 on the last group of the last slice.
  - out_eof = 1 on the last group of the frame.
  - With no issue in the previous cycle: out_valid=0, out_eol=0, out_eof=0; out_sel holds.
- Restart: start while in RUN or DONE with valid config restarts from slice 0, line 0 and enters RUN. Any group issued in the same cycle is still reported next cycle, but with out_eol=0 and out_eof=0.
- Config inputs are sampled continuously. They must be stable while busy; changing them mid-frame is undefined.

Test Plan:
- Nominal frame: spl=2, width=16, height=2, eoc=4, buffers non-empty, ready=1, start pulse.
  - rd_en = 01 x4, 10 x4, 01 x4, 10 x4, contiguous.
  - out_eol on outputs 8 and 16; out_eof on output 16 only.
  - busy high for 17 cycles (16 RUN + 1 DONE), then IDLE.
- Partial last group: spl=1, width=8, height=1, eoc=3.
  - Outputs 1111 then 0111, with out_eol=out_eof=1 on the second output.
- Stalls: as the nominal case, with buf_empty[1] high for 5 cycles mid-chunk and out_ready low for 3 cycles.
  - rd_en=0 during the stalls; counters hold; the resulting output sequence is identical to the nominal case.
- Config errors: start with spl=0, then with width=10.
  - cfg_err=1 and busy=0 both times.
  - A following valid start clears cfg_err and runs the frame.
- Reset/restart: rst asserted mid-frame → all outputs 0 next cycle. start asserted mid-line → next rd_en=01, grp_cnt restarts at 0.
- Boundary: spl=MAX_NBR_SLICES=2, width=2560 (640 groups), height=1 → 1280 reads, single out_eof, grp_cnt wraps cleanly.

Source files
------------

// File: rtl/slice_rd_sched_if.sv
// Handshake/config bundle between the slice read scheduler and its environment.
// The slave side is the scheduler. The master side drives config, buffer status and ready.
interface slice_rd_sched_if #(
    parameter int MAX_NBR_SLICES  = 2,
    parameter int MAX_SLICE_WIDTH = 2560
);
    localparam int SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
    localparam int WID_W = $clog2(MAX_SLICE_WIDTH);

    logic                      start;
    logic [9:0]                slices_per_line;
    logic [WID_W-1:0]          slice_width;
    logic [15:0]               frame_height;
    logic [2:0]                eoc_valid_pixs;
    logic [MAX_NBR_SLICES-1:0] buf_empty;
    logic                      out_ready;

    logic [MAX_NBR_SLICES-1:0] rd_en;
    logic [SEL_W-1:0]          rd_sel;
    logic [SEL_W-1:0]          out_sel;
    logic [3:0]                out_valid;
    logic                      out_eol;
    logic                      out_eof;
    logic                      busy;
    logic                      cfg_err;

    modport master (
        output start, slices_per_line, slice_width, frame_height, eoc_valid_pixs,
               buf_empty, out_ready,
        input  rd_en, rd_sel, out_sel, out_valid, out_eol, out_eof, busy, cfg_err
    );

    modport slave (
        input  start, slices_per_line, slice_width, frame_height, eoc_valid_pixs,
               buf_empty, out_ready,
        output rd_en, rd_sel, out_sel, out_valid, out_eol, out_eof, busy, cfg_err
    );
endinterface

// File: rtl/slice_rd_sched.sv
// Read scheduler for the per-slice output sync buffers: walks slices left to right one chunk
// at a time, issuing one-hot reads, and tags the merged 4-pixel stream with valid/eol/eof.
module slice_rd_sched #(
    parameter int MAX_NBR_SLICES  = 2,
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  logic                clk_out_int,
    input  logic                rst,
    slice_rd_sched_if.slave     bus
);
    localparam int SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
    localparam int WID_W = $clog2(MAX_SLICE_WIDTH);
    localparam int GRP_W = $clog2((MAX_SLICE_WIDTH >> 2) + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [GRP_W-1:0]          r_grp_cnt;
    logic [GRP_W-1:0]          w_grp_nxt;
    logic [SEL_W-1:0]          r_rd_sel;
    logic [SEL_W-1:0]          w_sel_nxt;
    logic [15:0]               r_line_cnt;
    logic [15:0]               w_line_nxt;
    logic                      r_cfg_err;
    logic                      w_cfg_err_nxt;
    logic [MAX_NBR_SLICES-1:0] w_rd_en;
    logic                      w_issue;
    logic                      w_restart;
    logic                      w_cfg_ok;
    logic [WID_W-1:0]          w_last_grp;
    logic                      w_grp_last;
    logic                      w_sel_last;
    logic                      w_line_last;

    logic [SEL_W-1:0]          r_out_sel;
    logic [3:0]                r_out_valid;
    logic                      r_out_eol;
    logic                      r_out_eof;

    function automatic logic [3:0] eoc_mask(input logic [2:0] n);
        logic [3:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign w_cfg_ok    = (bus.slices_per_line != 10'd0) &&
                         (bus.slices_per_line <= 10'(MAX_NBR_SLICES)) &&
                         (bus.slice_width >= WID_W'(8)) &&
                         (bus.slice_width[1:0] == 2'b00) &&
                         (bus.frame_height != 16'd0);
    assign w_last_grp  = (bus.slice_width >> 2) - WID_W'(1);
    assign w_grp_last  = (WID_W'(r_grp_cnt) == w_last_grp);
    assign w_sel_last  = (10'(r_rd_sel) == (bus.slices_per_line - 10'd1));
    assign w_line_last = (r_line_cnt == (bus.frame_height - 16'd1));

    // Next-state, read issue and position counters.
    always_comb begin
        w_state_nxt   = r_state;
        w_grp_nxt     = r_grp_cnt;
        w_sel_nxt     = r_rd_sel;
        w_line_nxt    = r_line_cnt;
        w_cfg_err_nxt = r_cfg_err;
        w_issue       = 1'b0;
        w_restart     = 1'b0;
        w_rd_en       = '0;
        case (r_state)
            ST_RUN: begin
                w_issue = ~bus.buf_empty[r_rd_sel] & bus.out_ready;
                if (w_issue) begin
                    w_rd_en[r_rd_sel] = 1'b1;
                    if (w_grp_last) begin
                        w_grp_nxt = '0;
                        if (w_sel_last) begin
                            w_sel_nxt  = '0;
                            w_line_nxt = r_line_cnt + 16'd1;
                            if (w_line_last) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_state_nxt = ST_RUN;
                            end
                        end else begin
                            w_sel_nxt = r_rd_sel + SEL_W'(1);
                        end
                    end else begin
                        w_grp_nxt = r_grp_cnt + GRP_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // A start in any state overrides the normal walk; a bad config only flags the error.
        if (bus.start) begin
            if (w_cfg_ok) begin
                w_restart     = (r_state != ST_IDLE);
                w_state_nxt   = ST_RUN;
                w_grp_nxt     = '0;
                w_sel_nxt     = '0;
                w_line_nxt    = 16'd0;
                w_cfg_err_nxt = 1'b0;
            end else begin
                w_cfg_err_nxt = 1'b1;
            end
        end else begin
            w_restart = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_out_int) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grp_cnt  <= '0;
            r_rd_sel   <= '0;
            r_line_cnt <= 16'd0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grp_cnt  <= w_grp_nxt;
            r_rd_sel   <= w_sel_nxt;
            r_line_cnt <= w_line_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
        end
    end

    // Output tags, one cycle behind rd_en so they line up with buffer read data.
    always_ff @(posedge clk_out_int) begin
        if (rst) begin
            r_out_sel   <= '0;
            r_out_valid <= 4'b0000;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (w_issue) begin
            r_out_sel   <= r_rd_sel;
            r_out_valid <= w_grp_last ? eoc_mask(bus.eoc_valid_pixs) : 4'b1111;
            r_out_eol   <= w_grp_last & w_sel_last & ~w_restart;
            r_out_eof   <= w_grp_last & w_sel_last & w_line_last & ~w_restart;
        end else begin
            r_out_valid <= 4'b0000;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.rd_sel    = r_rd_sel;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_eol   = r_out_eol;
    assign bus.out_eof   = r_out_eof;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_slice_rd_sched.sv
// Scoreboard bench for slice_rd_sched: a frame-level reference model predicts reads and
// pushes expected output groups; an independent monitor pops and compares them.
module tb_slice_rd_sched;
    localparam int NS = 2;
    localparam int MW = 2560;

    logic clk = 1'b0;
    logic rst = 1'b1;

    slice_rd_sched_if #(.MAX_NBR_SLICES(NS), .MAX_SLICE_WIDTH(MW)) bus ();

    slice_rd_sched #(.MAX_NBR_SLICES(NS), .MAX_SLICE_WIDTH(MW)) dut (
        .clk_out_int (clk),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;
        logic [3:0] valid;
        logic       eol;
        logic       eof;
    } item_t;

    item_t sb[$];
    item_t frame_q[$];
    int    total = 0;
    int    bad   = 0;
    int    fi    = 0;
    bit    run_m = 1'b0;
    bit    done_m = 1'b0;
    bit    cerr_m = 1'b0;
    bit    mon_en = 1'b0;
    int    eof_seen = 0;
    int    busy_cnt = 0;
    int    rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cfg_ok();
        return (bus.slices_per_line >= 1) && (bus.slices_per_line <= NS) &&
               (bus.slice_width >= 8) && (bus.slice_width % 4 == 0) &&
               (bus.frame_height != 0);
    endfunction

    // Whole frame as an ordered list of output groups, straight from the frame geometry.
    task automatic build_frame();
        int ng;
        int nv;
        item_t it;
        frame_q.delete();
        ng = int'(bus.slice_width) / 4;
        nv = (bus.eoc_valid_pixs == 0) ? 4 : int'(bus.eoc_valid_pixs);
        for (int l = 0; l < int'(bus.frame_height); l++)
            for (int s = 0; s < int'(bus.slices_per_line); s++)
                for (int g = 0; g < ng; g++) begin
                    it.sel   = s[0];
                    it.valid = (g == ng - 1) ? 4'((1 << nv) - 1) : 4'hF;
                    it.eol   = (g == ng - 1) && (s == int'(bus.slices_per_line) - 1);
                    it.eof   = it.eol && (l == int'(bus.frame_height) - 1);
                    frame_q.push_back(it);
                end
    endtask

    always @(negedge clk) begin
        item_t e;
        if (mon_en) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_valid", 32'(bus.out_valid), 32'(e.valid));
                chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
                chk("out_eol", 32'(bus.out_eol), 32'(e.eol));
                chk("out_eof", 32'(bus.out_eof), 32'(e.eof));
                if (bus.out_eof) eof_seen++;
            end else begin
                chk("idle_out", {28'd0, bus.out_valid | {2'b00, bus.out_eol, bus.out_eof}}, 32'd0);
            end
        end
    end

    task automatic tick(input bit st, input bit rs);
        bit                iss;
        logic [NS-1:0]     exp_rd;
        item_t             it;
        bus.start = st;
        rst       = rs;
        @(negedge clk);
        #1;
        iss    = run_m && !bus.buf_empty[frame_q[fi].sel] && bus.out_ready;
        exp_rd = '0;
        if (iss) exp_rd[frame_q[fi].sel] = 1'b1;
        chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
        chk("busy", 32'(bus.busy), 32'(run_m || done_m));
        chk("cfg_err", 32'(bus.cfg_err), 32'(cerr_m));
        if (run_m) chk("rd_sel", 32'(bus.rd_sel), 32'(frame_q[fi].sel));
        busy_cnt += int'(bus.busy);
        if (bus.rd_en != '0) rd_cnt++;
        if (rs) begin
            run_m  = 1'b0;
            done_m = 1'b0;
            cerr_m = 1'b0;
            sb.delete();
        end else begin
            if (iss) begin
                it = frame_q[fi];
                if (st && cfg_ok()) begin
                    it.eol = 1'b0;
                    it.eof = 1'b0;
                end
                sb.push_back(it);
                fi++;
            end
            if (done_m) done_m = 1'b0;
            else if (run_m && fi == frame_q.size()) begin
                run_m  = 1'b0;
                done_m = 1'b1;
            end
            if (st) begin
                if (cfg_ok()) begin
                    build_frame();
                    fi     = 0;
                    run_m  = 1'b1;
                    done_m = 1'b0;
                    cerr_m = 1'b0;
                end else begin
                    cerr_m = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic set_cfg(input int spl, input int w, input int fh, input int eoc);
        bus.slices_per_line = 10'(spl);
        bus.slice_width     = 12'(w);
        bus.frame_height    = 16'(fh);
        bus.eoc_valid_pixs  = 3'(eoc);
        bus.buf_empty       = '0;
        bus.out_ready       = 1'b1;
    endtask

    task automatic run_until_idle(input bit rnd, input int budget);
        int c = 0;
        while ((run_m || done_m) && c < budget) begin
            if (rnd) begin
                bus.buf_empty = NS'($urandom);
                bus.out_ready = ($urandom % 4) != 0;
            end
            tick(1'b0, 1'b0);
            c++;
        end
        if (c >= budget) begin
            total++;
            bad++;
            $display("FAIL timeout: frame still busy after %0d cycles", budget);
        end
        bus.buf_empty = '0;
        bus.out_ready = 1'b1;
        tick(1'b0, 1'b0);
    endtask

    initial begin
        set_cfg(2, 16, 2, 4);
        bus.start = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("reset_state", {bus.rd_en, bus.out_valid, bus.out_eol, bus.out_eof, bus.busy,
                            bus.cfg_err, bus.rd_sel, bus.out_sel}, 32'd0);

        // Nominal frame, also measuring how long busy stays high.
        busy_cnt = 0;
        tick(1'b1, 1'b0);
        run_until_idle(1'b0, 100);
        chk("busy_len", 32'(busy_cnt), 32'd17);

        set_cfg(1, 8, 1, 3);
        tick(1'b1, 1'b0);
        run_until_idle(1'b0, 100);

        // Nominal frame with an empty slice-1 buffer mid-chunk and a ready drop.
        set_cfg(2, 16, 2, 4);
        tick(1'b1, 1'b0);
        for (int c = 1; c < 60 && (run_m || done_m); c++) begin
            bus.buf_empty = (c >= 6 && c < 11) ? 2'b10 : 2'b00;
            bus.out_ready = !(c >= 14 && c < 17);
            tick(1'b0, 1'b0);
        end
        run_until_idle(1'b0, 100);

        set_cfg(0, 16, 2, 4);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("cfg_err_spl0", {30'd0, bus.cfg_err, bus.busy}, 32'd2);
        set_cfg(2, 10, 2, 4);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("cfg_err_w10", {30'd0, bus.cfg_err, bus.busy}, 32'd2);
        set_cfg(2, 16, 2, 4);
        tick(1'b1, 1'b0);
        chk("cfg_err_clr", 32'(bus.cfg_err), 32'd0);
        run_until_idle(1'b0, 100);

        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("rst_mid", {bus.rd_en, bus.out_valid, bus.out_eol, bus.out_eof, bus.busy,
                        bus.cfg_err, bus.rd_sel, bus.out_sel}, 32'd0);
        tick(1'b0, 1'b0);

        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("restart_rd_en", 32'(bus.rd_en), 32'd1);
        run_until_idle(1'b0, 100);

        set_cfg(2, 2560, 1, 4);
        eof_seen = 0;
        rd_cnt   = 0;
        tick(1'b1, 1'b0);
        run_until_idle(1'b0, 2000);
        chk("bound_reads", 32'(rd_cnt), 32'd1280);
        chk("bound_eof", 32'(eof_seen), 32'd1);

        // Random geometry and stalls, sometimes restarting part-way through.
        for (int f = 0; f < 24; f++) begin
            set_cfg($urandom_range(1, 2), 4 * $urandom_range(2, 12), $urandom_range(1, 3),
                    $urandom_range(0, 4));
            tick(1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) begin
                    bus.buf_empty = NS'($urandom);
                    bus.out_ready = ($urandom % 4) != 0;
                    tick(1'b0, 1'b0);
                end
                tick(1'b1, 1'b0);
            end
            run_until_idle(1'b1, 3000);
        end

        tick(1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
